// File: rtl/sklansky_pkg.sv
// Shared types and helpers for the Sklansky arithmetic blocks.
// Holds the (g,p) pair, merge functions and level count.
package sklansky_pkg;

  localparam int SUB_LATENCY = 3;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  function automatic pg_t black_merge(pg_t hi, pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic pg_t grey_merge(pg_t hi, pg_t lo);
    pg_t r;
    r = black_merge(hi, lo);
    r.p = 1'b0;
    return r;
  endfunction

  function automatic int clog2_levels(int w);
    int l;
    l = 0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << l) < w) l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/pg_merge_cell.sv
// Prefix-tree merge cell; GREY=1 keeps only the group generate.
// Used for both the Sklansky tree and the borrow-out cell.
module pg_merge_cell
  import sklansky_pkg::*;
#(
  parameter bit GREY = 1'b0
) (
  input  pg_t hi,
  input  pg_t lo,
  output pg_t y
);

  if (GREY) begin : g_grey
    assign y = grey_merge(hi, lo);
  end else begin : g_black
    assign y = black_merge(hi, lo);
  end

endmodule

// File: rtl/sklansky_subtractor.sv
// Pipelined Sklansky prefix subtractor: diff = a - b - bin, 3 stages.
// Define SKLANSKY_SUB_OVF_EN to add the registered signed-overflow port.
module sklansky_subtractor
  import sklansky_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout
`ifdef SKLANSKY_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int L = clog2_levels(W);
  localparam int H = (L + 1) / 2;

  logic s1_v, s2_v, s3_v;
  logic s1_rdy, s2_rdy, s3_rdy;

  assign s3_rdy    = ~s3_v | out_ready;
  assign s2_rdy    = ~s2_v | s3_rdy;
  assign s1_rdy    = ~s1_v | s2_rdy;
  assign in_ready  = s1_rdy;
  assign out_valid = s3_v;

  logic [W-1:0] s1_p, s1_g;
  logic         s1_cin;
  pg_t          s2_nd [W];
  logic [W-1:0] s2_p;
  logic         s2_gm;
`ifdef SKLANSKY_SUB_OVF_EN
  logic s1_am, s1_bm, s2_am, s2_bm;
`endif

  // Node 0 is the carry-in; node n carries bit n-1.
  pg_t n0 [W];
  assign n0[0] = '{g: s1_cin, p: 1'b0};
  for (genvar n = 1; n < W; n++) begin : g_n0
    assign n0[n] = '{g: s1_g[n-1], p: s1_p[n-1]};
  end

  for (genvar k = 1; k <= L; k++) begin : lvl
    pg_t src [W];
    pg_t nd  [W];
    for (genvar n = 0; n < W; n++) begin : g_node
      if (k == 1) begin : g_in0
        assign src[n] = n0[n];
      end else if (k == H + 1) begin : g_inr
        assign src[n] = s2_nd[n];
      end else begin : g_inl
        assign src[n] = lvl[k-1].nd[n];
      end
      if (((n >> (k - 1)) & 1) == 1) begin : g_m
        localparam int LO =
          (n & ~((1 << k) - 1)) + (1 << (k - 1)) - 1;
        pg_merge_cell #(.GREY(1'b0)) u_cell (
          .hi(src[n]),
          .lo(src[LO]),
          .y (nd[n])
        );
      end else begin : g_pass
        assign nd[n] = src[n];
      end
    end
  end

  logic [W-1:0] gfin, pfin, diff_c;
  pg_t          bo_hi, bo;

  for (genvar n = 0; n < W; n++) begin : g_fin
    assign gfin[n] = lvl[L].nd[n].g;
    assign pfin[n] = lvl[L].nd[n].p;
  end

  assign diff_c = s2_p ^ gfin;
  assign bo_hi  = '{g: s2_gm, p: s2_p[W-1]};

  pg_merge_cell #(.GREY(1'b1)) u_bout (
    .hi(bo_hi),
    .lo(lvl[L].nd[W-1]),
    .y (bo)
  );

  logic unused_pg;
  assign unused_pg = ^{pfin, bo.p};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_p   <= '0;
      s1_g   <= '0;
      s1_cin <= 1'b0;
`ifdef SKLANSKY_SUB_OVF_EN
      s1_am  <= 1'b0;
      s1_bm  <= 1'b0;
`endif
    end else if (s1_rdy) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_p   <= a ^ ~b;
        s1_g   <= a & ~b;
        s1_cin <= ~bin;
`ifdef SKLANSKY_SUB_OVF_EN
        s1_am  <= a[W-1];
        s1_bm  <= b[W-1];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v  <= 1'b0;
      s2_p  <= '0;
      s2_gm <= 1'b0;
      for (int n = 0; n < W; n++) s2_nd[n] <= '0;
`ifdef SKLANSKY_SUB_OVF_EN
      s2_am <= 1'b0;
      s2_bm <= 1'b0;
`endif
    end else if (s2_rdy) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_p  <= s1_p;
        s2_gm <= s1_g[W-1];
        for (int n = 0; n < W; n++) s2_nd[n] <= lvl[H].nd[n];
`ifdef SKLANSKY_SUB_OVF_EN
        s2_am <= s1_am;
        s2_bm <= s1_bm;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_v <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SKLANSKY_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (s3_rdy) begin
      s3_v <= s2_v;
      if (s2_v) begin
        diff <= diff_c;
        bout <= ~bo.g;
`ifdef SKLANSKY_SUB_OVF_EN
        ovf  <= (s2_am ^ s2_bm) & (diff_c[W-1] ^ s2_am);
`endif
      end
    end
  end

endmodule

// File: tb/tb_sklansky_subtractor.sv
// Bench for sklansky_subtractor: directed vectors, stall, reset, random.
// Checks ovf only when SKLANSKY_SUB_OVF_EN is defined.
module tb_sklansky_subtractor;
  import sklansky_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SKLANSKY_SUB_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  sklansky_subtractor #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout)
`ifdef SKLANSKY_SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic in_fire, out_fire;
  logic [W-1:0] o_diff;
  logic o_bout, o_ovf;

  function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb,
                                 logic mbin);
    exp_t m;
    int ua, ub, sa, sb, r;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = sa - sb - int'(mbin);
    m.diff = W'(ua - ub - int'(mbin));
    m.bout = (ua < ub + int'(mbin));
    m.ovf  = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Called at a negedge with inputs already driven; returns at next negedge.
  task automatic tick();
    exp_t e;
    #1;
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    o_diff   = diff;
    o_bout   = bout;
`ifdef SKLANSKY_SUB_OVF_EN
    o_ovf    = ovf;
`else
    o_ovf    = 1'b0;
`endif
    if (out_valid && !out_ready && exp_q.size() != 0)
      chk("held_diff", 64'(diff), 64'(exp_q[0].diff));
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out: got diff %0h with no beat pending",
                 diff);
      end else begin
        e = exp_q.pop_front();
        chk("sb_diff", 64'(diff), 64'(e.diff));
        chk("sb_bout", 64'(bout), 64'(e.bout));
`ifdef SKLANSKY_SUB_OVF_EN
        chk("sb_ovf", 64'(ovf), 64'(e.ovf));
`endif
      end
    end
    if (in_fire) exp_q.push_back(model(a, b, bin));
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    in_valid  = 1'b1;
    a         = v.a;
    b         = v.b;
    bin       = v.bin;
    out_ready = 1'b1;
    tick();
    chk("vec_accept", 64'(in_fire), 64'(1));
    in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (out_fire) begin
        lat = i;
        break;
      end
    end
    chk("vec_latency", 64'(lat), 64'(SUB_LATENCY));
    chk("vec_diff", 64'(o_diff), 64'(v.diff));
    chk("vec_bout", 64'(o_bout), 64'(v.bout));
`ifdef SKLANSKY_SUB_OVF_EN
    chk("vec_ovf", 64'(o_ovf), 64'(v.ovf));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t         vt [10];
    logic [W-1:0] sa [5];
    logic [W-1:0] sb [5];
    int idx, first, last, nout, stray;

    vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vt[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vt[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[7] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[8] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
    vt[9] = '{8'h3C, 8'hC3, 1'b0, 8'h79, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_diff", 64'(diff), 64'(0));
    chk("rst_bout", 64'(bout), 64'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    for (int i = 0; i < 5; i++) begin
      sa[i] = W'($urandom);
      sb[i] = W'($urandom);
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = (idx < 5);
      a   = sa[idx % 5];
      b   = sb[idx % 5];
      bin = 1'b0;
      tick();
      if (in_fire) idx++;
    end
    chk("stall_accepted", 64'(idx), 64'(3));
    #1;
    chk("stall_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    first = -1;
    last  = -1;
    nout  = 0;
    for (int c = 0; c < 16; c++) begin
      in_valid = (idx < 5);
      a = sa[idx % 5];
      b = sb[idx % 5];
      tick();
      if (in_fire) idx++;
      if (out_fire) begin
        if (first < 0) first = c;
        last = c;
        nout++;
      end
    end
    chk("stall_outputs", 64'(nout), 64'(5));
    chk("stall_no_gaps", 64'(last - first), 64'(4));

    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 8'h33;
    b = 8'h11;
    tick();
    a = 8'h44;
    b = 8'h22;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_diff", 64'(diff), 64'(0));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_vec('{8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0});
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_fire) stray++;
    end
    chk("no_stale_beats", 64'(stray), 64'(0));

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      bin       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
